reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised register file with two combinational read ports and one synchronous write port. Register 0 is hard-wired zero. A per-register scoreboard tracks destinations reserved by in-flight multi-cycle operations, so the issue stage can stall on read-after-write hazards. Successor to the fixed 16x16 register file; sits between decode/issue and the ALU operand muxes.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W registers
CNT_W, ADDR_W+1, width of pending-reservation counter

Ports:
clk  input  1  rising-edge clock
nClear  input  1  asynchronous active-low reset; clears all registers, busy bits, counter, flags
Aaddr  input  ADDR_W  read port A address
Baddr  input  ADDR_W  read port B address
A  output  DATA_W  read port A data
B  output  DATA_W  read port B data
A_busy  output  1  register at Aaddr has a pending reservation
B_busy  output  1  register at Baddr has a pending reservation
Caddr  input  ADDR_W  write address
C  input  DATA_W  write data
load  input  1  write enable
rsv_valid  input  1  reserve destination rsv_addr this cycle
rsv_addr  input  ADDR_W  destination to mark busy
busy_cnt  output  CNT_W  number of registers currently busy
rsv_conflict  output  1  registered one-cycle pulse: reservation hit an already-busy register

Behaviour:
- Reset (nClear=0, async): all registers 0, all busy bits 0, busy_cnt=0, rsv_conflict=0. A/B read 0; A_busy/B_busy=0.
- Write: at posedge, if load=1 and Caddr!=0, reg[Caddr]<=C. Writes to address 0 are discarded.
- Reads: combinational. A=reg[Aaddr], B=reg[Baddr]. Address 0 always returns 0.
- Without bypass, a same-cycle write is visible on the next cycle.
- Scoreboard, per posedge, in this priority order:
  - A write with load=1 to a busy register clears its busy bit.
  - rsv_valid=1 with rsv_addr!=0 sets busy[rsv_addr].
  - Reserve and write to the same address in the same cycle: the busy bit ends at 1, because the reserve wins for a new in-flight op.
  - Reserve of address 0 is ignored: no busy bit, no count, no conflict.
- Writes to non-busy registers are legal and do not change the scoreboard.
- A_busy=busy[Aaddr] and B_busy=busy[Baddr], combinational. busy[0] is always 0.
- busy_cnt equals the popcount of busy bits and is maintained incrementally:
  - +1 when a reserve sets a previously clear bit.
  - -1 when a write clears a set bit.
  - Same-address reserve+write on a busy register gives a net 0 change.
- busy_cnt never exceeds 2**ADDR_W-1 and never goes below 0.
- rsv_conflict: registered, high for exactly one cycle after a reserve to a register that was busy and is not cleared by a same-cycle write. The busy bit stays 1 and the count is unchanged.
- nClear asserted mid-operation discards all pending reservations. No write completes in a cycle where nClear=0.

Optional Feature:
Macro: REG_FILE_BYPASS_EN
- Defined: write-through forwarding. If load=1, Caddr!=0 and Caddr==Aaddr, then A=C and A_busy=0 in the same cycle; likewise for B. This lets the writeback cycle also release the stall.
- Undefined: no forwarding. A/B/A_busy/B_busy reflect registered state only. Operand latency after a write is 1 cycle.

Decomposition:
- Package reg_file_pkg holds:
  - default DATA_W/ADDR_W constants
  - ZERO_REG address constant (0)
  - typedefs for reg address and data word
- One sub-module, reg_file_scoreboard, holds the busy vector, busy_cnt and rsv_conflict logic. Inputs: clk, nClear, rsv_valid, rsv_addr, load, Caddr. Outputs: busy vector, busy_cnt, rsv_conflict.
- Storage array and read muxing stay in the top level.

Test Plan:
- Reset, write 16'hBEEF to reg 5, read Aaddr=5 next cycle -> A=16'hBEEF, A_busy=0. Write 16'h1234 to reg 0 -> Aaddr=0 reads 16'h0000.
- Reserve reg 3, then read Aaddr=3, Baddr=3 -> A_busy=B_busy=1, busy_cnt=1. Write reg 3 = 16'h00AA -> next cycle busy clear, busy_cnt=0, A=16'h00AA.
- Reserve reg 7 twice on consecutive cycles -> rsv_conflict pulses for one cycle after the second reserve; busy_cnt stays 1.
- Reg 9 busy; same cycle reserve 9 + write 9 = 16'h5555 -> reg9=16'h5555, busy[9]=1, busy_cnt unchanged, no rsv_conflict.
- Reserve regs 1..15 -> busy_cnt=15. Assert nClear for one cycle mid-sequence -> busy_cnt=0, all regs 0, no A_busy.
- With REG_FILE_BYPASS_EN, reg 4 busy, load=1, Caddr=4, C=16'hCAFE, Aaddr=4 -> same cycle A=16'hCAFE, A_busy=0. Without the macro -> A=old value, A_busy=1 that cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard for in-flight destinations: busy vector, running count
// and a registered conflict pulse for reserves that land on an already-busy register.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic                   clk,
  input  logic                   nClear,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   load,
  input  logic [ADDR_W-1:0]      Caddr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [CNT_W-1:0]       busy_cnt,
  output logic                   rsv_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic             rsv_hit;
  logic             wr_hit;
  logic             same_addr;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             conflict_nxt;
  logic [DEPTH-1:0] busy_nxt;

  // Write clears first, reserve sets last, so a same-address pair leaves the bit set.
  always_comb begin
    rsv_hit      = rsv_valid && (rsv_addr != ADDR_W'(ZERO_REG));
    wr_hit       = load && (Caddr != ADDR_W'(ZERO_REG));
    same_addr    = rsv_hit && wr_hit && (rsv_addr == Caddr);
    cnt_inc      = rsv_hit && !busy[rsv_addr];
    cnt_dec      = wr_hit && busy[Caddr] && !same_addr;
    conflict_nxt = rsv_hit && busy[rsv_addr] && !same_addr;
    busy_nxt     = busy;
    if (wr_hit)  busy_nxt[Caddr]    = 1'b0;
    if (rsv_hit) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      busy         <= '0;
      busy_cnt     <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      busy         <= busy_nxt;
      busy_cnt     <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      rsv_conflict <= conflict_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file (2 read / 1 write, reg 0 hard-wired zero) with a RAW scoreboard.
// Optional write-through forwarding to the read ports under REG_FILE_BYPASS_EN.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              nClear,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_busy,
  output logic              B_busy,
  input  logic [ADDR_W-1:0] Caddr,
  input  logic [DATA_W-1:0] C,
  input  logic              load,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic              rsv_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;

  assign wr_en = load && (Caddr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[Caddr] <= C;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk          (clk),
    .nClear       (nClear),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .load         (load),
    .Caddr        (Caddr),
    .busy         (busy),
    .busy_cnt     (busy_cnt),
    .rsv_conflict (rsv_conflict)
  );

  always_comb begin
    A      = (Aaddr == ADDR_W'(ZERO_REG)) ? '0 : mem[Aaddr];
    B      = (Baddr == ADDR_W'(ZERO_REG)) ? '0 : mem[Baddr];
    A_busy = busy[Aaddr];
    B_busy = busy[Baddr];
`ifdef REG_FILE_BYPASS_EN
    // Forwarding the writeback also releases the stall in the same cycle.
    if (wr_en && (Caddr == Aaddr)) begin
      A      = C;
      A_busy = 1'b0;
    end
    if (wr_en && (Caddr == Baddr)) begin
      B      = C;
      B_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed cases then randomized traffic
// against an array-based reference model.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          nClear;
  logic [AW-1:0] Aaddr, Baddr, Caddr, rsv_addr;
  logic [DW-1:0] A, B, C;
  logic          A_busy, B_busy, load, rsv_valid, rsv_conflict;
  logic [CW-1:0] busy_cnt;

  data_t m_reg  [DEPTH];
  bit    m_busy [DEPTH];
  bit    m_conf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk          (clk),
    .nClear       (nClear),
    .Aaddr        (Aaddr),
    .Baddr        (Baddr),
    .A            (A),
    .B            (B),
    .A_busy       (A_busy),
    .B_busy       (B_busy),
    .Caddr        (Caddr),
    .C            (C),
    .load         (load),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .busy_cnt     (busy_cnt),
    .rsv_conflict (rsv_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  // Reference behaviour at a rising edge, straight from the register-file rules.
  task automatic model_step();
    bit wr, rs;
    wr = load && (Caddr != 0);
    rs = rsv_valid && (rsv_addr != 0);
    m_conf = rs && m_busy[rsv_addr] && !(wr && (Caddr == rsv_addr));
    if (wr) begin
      m_reg[Caddr]  = C;
      m_busy[Caddr] = 1'b0;
    end
    if (rs) m_busy[rsv_addr] = 1'b1;
  endtask

  task automatic check_outputs();
    data_t ea, eb;
    bit    eab, ebb;
    int    cnt;
    ea  = (Aaddr == 0) ? '0 : m_reg[Aaddr];
    eb  = (Baddr == 0) ? '0 : m_reg[Baddr];
    eab = m_busy[Aaddr];
    ebb = m_busy[Baddr];
`ifdef REG_FILE_BYPASS_EN
    if (nClear && load && (Caddr != 0) && (Caddr == Aaddr)) begin ea = C; eab = 1'b0; end
    if (nClear && load && (Caddr != 0) && (Caddr == Baddr)) begin eb = C; ebb = 1'b0; end
`endif
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
    chk("A",            32'(A),            32'(ea));
    chk("B",            32'(B),            32'(eb));
    chk("A_busy",       32'(A_busy),       32'(eab));
    chk("B_busy",       32'(B_busy),       32'(ebb));
    chk("busy_cnt",     32'(busy_cnt),     32'(cnt));
    chk("rsv_conflict", 32'(rsv_conflict), 32'(m_conf));
  endtask

  task automatic drive(input bit ld, input int ca, input logic [DW-1:0] cd,
                       input bit rv, input int ra, input int aa, input int ba);
    load      = ld;
    Caddr     = AW'(ca);
    C         = cd;
    rsv_valid = rv;
    rsv_addr  = AW'(ra);
    Aaddr     = AW'(aa);
    Baddr     = AW'(ba);
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    if (nClear) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nClear = 1'b0;
    model_clear();
    drive(0, 0, '0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    nClear = 1'b1;
  endtask

  initial begin
    nClear = 1'b0;
    load = 1'b0; Caddr = '0; C = '0; rsv_valid = 1'b0; rsv_addr = '0;
    Aaddr = '0; Baddr = '0;
    model_clear();
    @(negedge clk);
    do_reset();
    chk("rst_cnt",  32'(busy_cnt),     32'd0);
    chk("rst_conf", 32'(rsv_conflict), 32'd0);

    // Basic write/read and the zero register
    drive(1, 5, 16'hBEEF, 0, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 5, 0);
    chk("a_beef",  32'(A),      32'h0000BEEF);
    chk("a_busy5", 32'(A_busy), 32'd0);
    tick();
    drive(1, 0, 16'h1234, 0, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 0, 0);
    chk("a_zero", 32'(A), 32'd0);
    tick();

    // Reserve then writeback clears
    drive(0, 0, '0, 1, 3, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 3, 3);
    chk("a_busy3", 32'(A_busy),   32'd1);
    chk("b_busy3", 32'(B_busy),   32'd1);
    chk("cnt_r3",  32'(busy_cnt), 32'd1);
    tick();
    drive(1, 3, 16'h00AA, 0, 0, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 3, 3);
    chk("cnt_w3",  32'(busy_cnt), 32'd0);
    chk("a_00aa",  32'(A),        32'h000000AA);
    chk("a_clr3",  32'(A_busy),   32'd0);
    tick();

    // Double reserve -> single conflict pulse
    drive(0, 0, '0, 1, 7, 0, 0); tick();
    drive(0, 0, '0, 1, 7, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 7, 0);
    chk("conf7",     32'(rsv_conflict), 32'd1);
    chk("cnt7",      32'(busy_cnt),     32'd1);
    tick();
    drive(0, 0, '0, 0, 0, 7, 0);
    chk("conf7_end", 32'(rsv_conflict), 32'd0);
    tick();

    // Same-cycle reserve + write on a busy register
    drive(0, 0, '0, 1, 9, 0, 0); tick();
    drive(1, 9, 16'h5555, 1, 9, 0, 0); tick();
    drive(0, 0, '0, 0, 0, 9, 0);
    chk("a_5555",  32'(A),            32'h00005555);
    chk("busy9",   32'(A_busy),       32'd1);
    chk("cnt9",    32'(busy_cnt),     32'd2);
    chk("conf9",   32'(rsv_conflict), 32'd0);
    tick();

    // Write-through on a busy register
    drive(1, 4, 16'h1111, 0, 0, 0, 0); tick();
    drive(0, 0, '0, 1, 4, 0, 0); tick();
    drive(1, 4, 16'hCAFE, 0, 0, 4, 0);
`ifdef REG_FILE_BYPASS_EN
    chk("byp_a",    32'(A),      32'h0000CAFE);
    chk("byp_busy", 32'(A_busy), 32'd0);
`else
    chk("nobyp_a",    32'(A),      32'h00001111);
    chk("nobyp_busy", 32'(A_busy), 32'd1);
`endif
    tick();

    // Fill the scoreboard, then clear mid-sequence
    for (int i = 1; i < DEPTH; i++) begin
      drive(0, 0, '0, 1, i, i, 0); tick();
    end
    drive(0, 0, '0, 0, 0, 0, 0);
    chk("cnt_full", 32'(busy_cnt), 32'(DEPTH - 1));
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, 0, 0, i, DEPTH - 1 - i);
      chk("clr_a",    32'(A),      32'd0);
      chk("clr_busy", 32'(A_busy), 32'd0);
    end
    chk("clr_cnt", 32'(busy_cnt), 32'd0);
    tick();

    // Randomized traffic on a narrow address window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      int win;
      win = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 5;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 99) < 40, $urandom_range(0, win), DW'($urandom),
              $urandom_range(0, 99) < 45, $urandom_range(0, win),
              $urandom_range(0, win), $urandom_range(0, win));
        tick();
      end
    end

    drive(0, 0, '0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
